// File: rtl/gtp_rx_comma_aligner.sv
// gtp_rx_comma_aligner
// Consumes the 2-byte 8b/10b-decoded RX word stream of a GTPE2 channel,
// finds the lane carrying the K28.5 comma, re-packs bytes so the comma sits
// in byte 0, and runs a lock/unlock machine that qualifies the output stream.
//
// Ports:
//   clk            RX user clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       input word qualifier (nothing advances while low)
//   in_data        decoded bytes, byte0 = [7:0] first in time
//   in_charisk     per-byte K flag
//   in_disperr     per-byte disparity error
//   in_notintable  per-byte invalid code
//   out_data       lane-aligned data (registered)
//   out_charisk    lane-aligned K flags (registered)
//   out_valid      aligned word valid, only while locked
//   locked         high in LOCKED state
//   lane           current alignment offset (1 = comma arrives in byte1)
//   err_total      saturating count of code-error words since reset
module gtp_rx_comma_aligner #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_charisk,
  input  logic [1:0]  in_disperr,
  input  logic [1:0]  in_notintable,
  output logic [15:0] out_data,
  output logic [1:0]  out_charisk,
  output logic        out_valid,
  output logic        locked,
  output logic        lane,
  output logic [15:0] err_total
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1
  } state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_LIM4  = 4'(ERR_LIMIT);

  function automatic logic is_comma(input logic k, input logic [7:0] b);
    return k && (b == COMMA);
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  lock_cnt_r, lock_cnt_s;
  logic [3:0]  err_cnt_r, err_cnt_s;
  logic        lane_r, lane_s;

  logic [15:0] prev_data_r;
  logic [1:0]  prev_k_r;
  logic [15:0] out_data_r, aligned_data_s;
  logic [1:0]  out_k_r, aligned_k_s;
  logic        out_valid_r, valid_s;
  logic        locked_r;
  logic [15:0] err_total_r, err_total_s;

  logic        word_err_s, c0_s, c1_s, comma_s, comma_lane_s;

  // Per-word classification; byte0 comma wins when both bytes carry one.
  always_comb begin
    word_err_s   = |(in_disperr | in_notintable);
    c0_s         = is_comma(in_charisk[0], in_data[7:0]);
    c1_s         = is_comma(in_charisk[1], in_data[15:8]);
    comma_s      = c0_s | c1_s;
    comma_lane_s = ~c0_s;
  end

  // State register with lock/error counters and lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= HUNT;
      lock_cnt_r <= 4'd0;
      err_cnt_r  <= 4'd0;
      lane_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      lock_cnt_r <= lock_cnt_s;
      err_cnt_r  <= err_cnt_s;
      lane_r     <= lane_s;
    end
  end

  // Next-state logic for the lock machine; only accepted words act.
  always_comb begin
    state_s    = state_r;
    lock_cnt_s = lock_cnt_r;
    err_cnt_s  = err_cnt_r;
    lane_s     = lane_r;
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (word_err_s) begin
            lock_cnt_s = 4'd0;
          end else if (comma_s) begin
            lane_s = comma_lane_s;
            if ((comma_lane_s == lane_r) || (lock_cnt_r == 4'd0)) begin
              lock_cnt_s = lock_cnt_r + 4'd1;
            end else begin
              lock_cnt_s = 4'd1;
            end
          end else begin
            lock_cnt_s = lock_cnt_r;
          end
          if (lock_cnt_s == LOCK_CNT4) begin
            state_s   = LOCKED;
            err_cnt_s = 4'd0;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          // A comma at the other lane is treated as an error and never moves the lane.
          if (word_err_s || (comma_s && (comma_lane_s != lane_r))) begin
            err_cnt_s = err_cnt_r + 4'd1;
          end else if (comma_s && (err_cnt_r != 4'd0)) begin
            err_cnt_s = err_cnt_r - 4'd1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
          if (err_cnt_s == ERR_LIM4) begin
            state_s    = HUNT;
            lock_cnt_s = 4'd0;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s    = HUNT;
          lock_cnt_s = 4'd0;
          err_cnt_s  = 4'd0;
          lane_s     = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output-next logic: byte re-packing, valid qualification, error tally.
  always_comb begin
    if (lane_r) begin
      // Comma sat in byte1 of prev: splice prev's high byte with cur's low byte.
      aligned_data_s = {in_data[7:0], prev_data_r[15:8]};
      aligned_k_s    = {in_charisk[0], prev_k_r[1]};
    end else begin
      aligned_data_s = prev_data_r;
      aligned_k_s    = prev_k_r;
    end
    valid_s = in_valid && (state_s == LOCKED);
    if (in_valid && word_err_s && (err_total_r != 16'hFFFF)) begin
      err_total_s = err_total_r + 16'd1;
    end else begin
      err_total_s = err_total_r;
    end
  end

  // Pipeline and output registers; data path holds while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data_r <= 16'd0;
      prev_k_r    <= 2'd0;
      out_data_r  <= 16'd0;
      out_k_r     <= 2'd0;
      out_valid_r <= 1'b0;
      locked_r    <= 1'b0;
      err_total_r <= 16'd0;
    end else begin
      out_valid_r <= valid_s;
      locked_r    <= (state_s == LOCKED);
      err_total_r <= err_total_s;
      if (in_valid) begin
        prev_data_r <= in_data;
        prev_k_r    <= in_charisk;
        out_data_r  <= aligned_data_s;
        out_k_r     <= aligned_k_s;
      end else begin
        prev_data_r <= prev_data_r;
        prev_k_r    <= prev_k_r;
        out_data_r  <= out_data_r;
        out_k_r     <= out_k_r;
      end
    end
  end

  assign out_data    = out_data_r;
  assign out_charisk = out_k_r;
  assign out_valid   = out_valid_r;
  assign locked      = locked_r;
  assign lane        = lane_r;
  assign err_total   = err_total_r;

endmodule

// File: tb/tb_gtp_rx_comma_aligner.sv
module tb_gtp_rx_comma_aligner;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_charisk;
  logic [1:0]  in_disperr;
  logic [1:0]  in_notintable;
  logic [15:0] out_data;
  logic [1:0]  out_charisk;
  logic        out_valid;
  logic        locked;
  logic        lane;
  logic [15:0] err_total;

  gtp_rx_comma_aligner #(
    .COMMA(8'hBC), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_charisk(in_charisk), .in_disperr(in_disperr), .in_notintable(in_notintable),
    .out_data(out_data), .out_charisk(out_charisk), .out_valid(out_valid),
    .locked(locked), .lane(lane), .err_total(err_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  k;
    logic        lk;
    logic        ln;
    logic [15:0] tot;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_locked;
  int          m_cnt, m_errc, m_total;
  bit          m_lane;
  logic [15:0] m_prev_d, m_od;
  logic [1:0]  m_prev_k, m_ok;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_cnt = 0; m_errc = 0; m_total = 0; m_lane = 0;
    m_prev_d = 16'h0000; m_prev_k = 2'b00; m_od = 16'h0000; m_ok = 2'b00;
  endtask

  // Model of one clock edge, written from the alignment/lock rules.
  task automatic model_step(input logic r, input logic v, input logic [15:0] d,
                            input logic [1:0] k, input logic [1:0] de, input logic [1:0] nt,
                            output exp_t e);
    bit err, c0, c1, has, cl;
    if (r) begin
      model_reset();
      e.v = 0; e.d = 16'h0000; e.k = 2'b00; e.lk = 0; e.ln = 0; e.tot = 16'h0000;
      return;
    end
    if (v) begin
      err = ((de | nt) != 2'b00);
      c0  = k[0] && (d[7:0] == 8'hBC);
      c1  = k[1] && (d[15:8] == 8'hBC);
      has = c0 || c1;
      cl  = !c0;
      // the output word uses the lane in force before this word
      if (m_lane) begin
        m_od = {d[7:0], m_prev_d[15:8]};
        m_ok = {k[0], m_prev_k[1]};
      end else begin
        m_od = m_prev_d;
        m_ok = m_prev_k;
      end
      m_prev_d = d;
      m_prev_k = k;
      if (!m_locked) begin
        if (err) m_cnt = 0;
        else if (has) begin
          if (cl == m_lane || m_cnt == 0) m_cnt = m_cnt + 1;
          else m_cnt = 1;
          m_lane = cl;
        end
        if (m_cnt == LOCK_COUNT) begin
          m_locked = 1;
          m_errc = 0;
        end
      end else begin
        if (err || (has && cl != m_lane)) m_errc = m_errc + 1;
        else if (has && m_errc > 0) m_errc = m_errc - 1;
        if (m_errc == ERR_LIMIT) begin
          m_locked = 0;
          m_cnt = 0;
        end
      end
      if (err && m_total < 65535) m_total = m_total + 1;
    end
    e.v = v && m_locked; e.d = m_od; e.k = m_ok;
    e.lk = m_locked; e.ln = m_lane; e.tot = 16'(m_total);
  endtask

  // Drive one cycle; the expected response is queued once the edge has happened.
  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] k,
                       input logic [1:0] de, input logic [1:0] nt, input logic r);
    exp_t e;
    rst = r; in_valid = v; in_data = d; in_charisk = k;
    in_disperr = de; in_notintable = nt;
    @(posedge clk);
    model_step(r, v, d, k, de, nt, e);
    q.push_back(e);
    #1;
  endtask

  task automatic word(input logic [15:0] d, input logic [1:0] k);
    drive(1'b1, d, k, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b1);
  endtask

  // Monitor: pops the expectation for the edge just past and compares.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid", {15'd0, out_valid}, {15'd0, e.v});
      chk("locked", {15'd0, locked}, {15'd0, e.lk});
      chk("lane", {15'd0, lane}, {15'd0, e.ln});
      chk("err_total", err_total, e.tot);
      if (e.v) begin
        chk("out_data", out_data, e.d);
        chk("out_charisk", {14'd0, out_charisk}, {14'd0, e.k});
      end
    end
  end

  initial begin
    int sel;
    bit fav;
    logic [15:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000;
    in_charisk = 2'b00; in_disperr = 2'b00; in_notintable = 2'b00;
    model_reset();

    // lock at lane 0
    do_reset(3);
    for (int i = 0; i < 7; i++) word(16'h50BC, 2'b01);

    // lock at lane 1 with alternating comma / data words
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) word(16'hBC11, 2'b10);
      else word(16'h2233, 2'b00);
    end

    // lane flip in HUNT restarts the count
    do_reset(1);
    for (int i = 0; i < 3; i++) word(16'h50BC, 2'b01);
    for (int i = 0; i < 5; i++) word(16'hBC11, 2'b10);

    // loss of lock with 8 disparity errors
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h1234, 2'b00, 2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) word(16'h5566, 2'b00);

    // relock, then errors interleaved with good commas
    for (int i = 0; i < 4; i++) word(16'hBC11, 2'b10);
    for (int g = 0; g < 4; g++) begin
      drive(1'b1, 16'h7788, 2'b00, 2'b01, 2'b00, 1'b0);
      drive(1'b1, 16'h7788, 2'b00, 2'b00, 2'b10, 1'b0);
      word(16'hBC11, 2'b10);
    end
    // wrong-lane comma while locked counts as an error
    for (int i = 0; i < 3; i++) word(16'h50BC, 2'b01);

    // stall for 5 cycles mid-stream
    for (int i = 0; i < 5; i++) drive(1'b0, 16'hBC11, 2'b10, 2'b11, 2'b11, 1'b0);
    word(16'h9ABC, 2'b00);

    // comma with notintable in HUNT clears the count
    do_reset(1);
    word(16'h50BC, 2'b01);
    word(16'h50BC, 2'b01);
    drive(1'b1, 16'h50BC, 2'b01, 2'b00, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) word(16'h50BC, 2'b01);

    // reset mid-lock
    do_reset(1);
    word(16'h0102, 2'b00);

    // randomized traffic
    fav = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) fav = ~fav;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        sel = $urandom_range(0, 99);
        d = 16'($urandom);
        if (sel < 10) drive(1'b0, d, 2'($urandom), 2'($urandom), 2'($urandom), 1'b0);
        else if (sel < 45) begin
          if (fav) word({8'hBC, d[7:0]}, {1'b1, d[0]});
          else word({d[15:8], 8'hBC}, {d[8], 1'b1});
        end else if (sel < 50) word({8'hBC, 8'hBC}, 2'b11);
        else if (sel < 55) begin
          if (fav) word({d[15:8], 8'hBC}, 2'b01);
          else word({8'hBC, d[7:0]}, 2'b10);
        end else if (sel < 62) drive(1'b1, d, 2'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 1'b0);
        else word(d, 2'($urandom_range(0, 3)));
      end
    end

    // err_total saturation
    do_reset(1);
    for (int i = 0; i < 65540; i++) drive(1'b1, 16'hBC11, 2'b10, 2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) word(16'hBC11, 2'b10);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
